// File: rtl/pulse_receiver_if.sv
// Event/status bundle between the pulse receiver and local logic.
// master = receiver side (drives event and status), slave = consumer side.
interface pulse_receiver_if #(
  parameter int CNT_W = 8
);
  logic             line_in;
  logic             event_ready;
  logic             clr_err;
  logic             event_valid;
  logic [CNT_W-1:0] event_cnt;
  logic [CNT_W-1:0] glitch_cnt;
  logic             overrun;
  logic             line_stuck;
  logic             stuck_seen;

  modport master (
    input  line_in, event_ready, clr_err,
    output event_valid, event_cnt, glitch_cnt, overrun, line_stuck, stuck_seen
  );

  modport slave (
    output line_in, event_ready, clr_err,
    input  event_valid, event_cnt, glitch_cnt, overrun, line_stuck, stuck_seen
  );
endinterface

// File: rtl/pulse_receiver.sv
// Single-wire stretched-pulse receiver: synchronises line_in, qualifies the
// high time (short = glitch, long = stuck line) and presents one event per
// valid pulse on a valid/ready handshake. Keeps event/glitch counts and
// sticky error flags.
module pulse_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 4,
  parameter int MAX_HIGH    = 12,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  pulse_receiver_if.master  bus
);

  // len must be able to hold MAX_HIGH+1 so the stuck comparison can fire
  localparam int LEN_W = $clog2(MAX_HIGH + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_HIGH + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, HOLD, STUCK} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d, len_inc;
  logic                   accept, glitch, stuck_enter;
  logic                   ev_valid_q;
  logic [CNT_W-1:0]       ev_cnt_q, gl_cnt_q;
  logic                   overrun_q, stuck_seen_q;

  assign s       = sync_q[SYNC_STAGES-1];
  assign len_inc = (len_q >= LEN_SAT) ? LEN_SAT : len_q + LEN_W'(1);

  // Synchroniser chain for the asynchronous line
  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.line_in};
  end

  // FSM state and high-time counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  // Next-state: measure high time, accept once at MIN_HIGH, flag stuck past MAX_HIGH
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    accept      = 1'b0;
    glitch      = 1'b0;
    stuck_enter = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = MEASURE;
          len_d   = LEN_W'(1);
        end
      end
      MEASURE: begin
        if (!s) begin
          state_d = IDLE;
          len_d   = '0;
          glitch  = 1'b1;
        end else begin
          len_d = len_inc;
          if (len_inc == LEN_W'(MIN_HIGH)) begin
            accept  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!s) begin
          state_d = IDLE;
          len_d   = '0;
        end else begin
          len_d = len_inc;
          if (len_inc > LEN_W'(MAX_HIGH)) begin
            state_d     = STUCK;
            stuck_enter = 1'b1;
          end
        end
      end
      STUCK: begin
        if (!s) begin
          state_d = IDLE;
          len_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        len_d   = '0;
      end
    endcase
  end

  // Event handshake and wrapping event counter; a new accept keeps valid high
  always_ff @(posedge clk) begin
    if (!rst) begin
      ev_valid_q <= 1'b0;
      ev_cnt_q   <= '0;
    end else begin
      if (accept) begin
        ev_valid_q <= 1'b1;
        ev_cnt_q   <= ev_cnt_q + CNT_W'(1);
      end else if (ev_valid_q && bus.event_ready) begin
        ev_valid_q <= 1'b0;
      end
    end
  end

  // Error bookkeeping; clr_err wins over a same-cycle set or increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      gl_cnt_q     <= '0;
      overrun_q    <= 1'b0;
      stuck_seen_q <= 1'b0;
    end else if (bus.clr_err) begin
      gl_cnt_q     <= '0;
      overrun_q    <= 1'b0;
      stuck_seen_q <= 1'b0;
    end else begin
      if (glitch && (gl_cnt_q != '1)) gl_cnt_q <= gl_cnt_q + CNT_W'(1);
      if (accept && ev_valid_q && !bus.event_ready) overrun_q <= 1'b1;
      if (stuck_enter) stuck_seen_q <= 1'b1;
    end
  end

  assign bus.event_valid = ev_valid_q;
  assign bus.event_cnt   = ev_cnt_q;
  assign bus.glitch_cnt  = gl_cnt_q;
  assign bus.overrun     = overrun_q;
  assign bus.line_stuck  = (state_q == STUCK);
  assign bus.stuck_seen  = stuck_seen_q;

endmodule

// File: tb/tb_pulse_receiver.sv
// Directed bench for pulse_receiver (SYNC_STAGES=2, MIN_HIGH=4, MAX_HIGH=12).
// Edge 0 is the first posedge that samples line_in high; outputs are sampled
// 1ns after each posedge.
module tb_pulse_receiver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pulse_receiver_if #(.CNT_W(8)) bus ();

  pulse_receiver #(
    .SYNC_STAGES(2), .MIN_HIGH(4), .MAX_HIGH(12), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.line_in = 1'b0;
    bus.clr_err = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  // Drive a pulse high for 'high' edges, record valid/stuck after each of 'total' edges
  task automatic run_pulse(input int high, input int total,
                           output logic [63:0] vh, output logic [63:0] sh);
    vh = '0;
    sh = '0;
    bus.line_in = 1'b1;
    for (int e = 0; e < total; e++) begin
      tick();
      vh[e] = bus.event_valid;
      sh[e] = bus.line_stuck;
      if (e == high - 1) bus.line_in = 1'b0;
    end
  endtask

  logic [63:0] vh, sh;

  initial begin
    bus.line_in     = 1'b0;
    bus.event_ready = 1'b0;
    bus.clr_err     = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid",  {63'd0, bus.event_valid}, 64'd0);
    chk("rst_evcnt",  {56'd0, bus.event_cnt},   64'd0);
    chk("rst_glcnt",  {56'd0, bus.glitch_cnt},  64'd0);
    chk("rst_ovr",    {63'd0, bus.overrun},     64'd0);
    chk("rst_stuck",  {63'd0, bus.line_stuck},  64'd0);
    chk("rst_seen",   {63'd0, bus.stuck_seen},  64'd0);
    rst = 1'b1;
    tick();

    // 8-cycle pulse, consumer ready: valid visible only after edge 5
    bus.event_ready = 1'b1;
    run_pulse(8, 12, vh, sh);
    chk("p8_valid_hist", vh, 64'h20);
    chk("p8_evcnt", {56'd0, bus.event_cnt}, 64'd1);
    chk("p8_glcnt", {56'd0, bus.glitch_cnt}, 64'd0);

    // 3-cycle pulse is a glitch
    run_pulse(3, 8, vh, sh);
    chk("p3_valid_hist", vh, 64'h0);
    chk("p3_glcnt", {56'd0, bus.glitch_cnt}, 64'd1);
    // 4-cycle pulse is the shortest accepted
    run_pulse(4, 8, vh, sh);
    chk("p4_valid_hist", vh, 64'h20);
    chk("p4_evcnt", {56'd0, bus.event_cnt}, 64'd2);
    // 299 more glitches: 300 total saturates at 255
    for (int i = 0; i < 299; i++) run_pulse(3, 8, vh, sh);
    chk("glitch_sat", {56'd0, bus.glitch_cnt}, 64'd255);
    chk("glitch_no_ev", {56'd0, bus.event_cnt}, 64'd2);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("clr_glcnt", {56'd0, bus.glitch_cnt}, 64'd0);

    // Two 8-cycle pulses 6 cycles apart, consumer stalled
    do_reset();
    bus.event_ready = 1'b0;
    run_pulse(8, 14, vh, sh);
    chk("ovr_p1_hist", vh, 64'h3FE0);
    chk("ovr_p1_flag", {63'd0, bus.overrun}, 64'd0);
    run_pulse(8, 14, vh, sh);
    chk("ovr_p2_hist", vh, 64'h3FFF);
    chk("ovr_evcnt", {56'd0, bus.event_cnt}, 64'd2);
    chk("ovr_flag", {63'd0, bus.overrun}, 64'd1);
    bus.event_ready = 1'b1;
    tick();
    chk("ovr_drain", {63'd0, bus.event_valid}, 64'd0);

    // Accept and handshake on the same edge: valid stays, no overrun
    do_reset();
    bus.event_ready = 1'b0;
    run_pulse(8, 14, vh, sh);
    bus.line_in = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 4) bus.event_ready = 1'b1;
      if (e == 5) begin
        bus.event_ready = 1'b0;
        chk("same_valid", {63'd0, bus.event_valid}, 64'd1);
        chk("same_ovr", {63'd0, bus.overrun}, 64'd0);
      end
    end
    bus.line_in = 1'b0;
    chk("same_evcnt", {56'd0, bus.event_cnt}, 64'd2);
    bus.event_ready = 1'b1;
    repeat (4) tick();

    // Line held high 20 cycles: one event, stuck from edge 14 through edge 21
    do_reset();
    run_pulse(20, 26, vh, sh);
    chk("stuck_valid_hist", vh, 64'h20);
    chk("stuck_hist", sh, 64'h3FC000);
    chk("stuck_evcnt", {56'd0, bus.event_cnt}, 64'd1);
    chk("stuck_seen", {63'd0, bus.stuck_seen}, 64'd1);
    chk("stuck_cleared", {63'd0, bus.line_stuck}, 64'd0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("stuck_seen_clr", {63'd0, bus.stuck_seen}, 64'd0);

    // Reset at edge 3 of a pulse with the line held high
    bus.line_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", {63'd0, bus.event_valid}, 64'd0);
    chk("mid_rst_evcnt", {56'd0, bus.event_cnt}, 64'd0);
    chk("mid_rst_stuck", {63'd0, bus.line_stuck}, 64'd0);
    rst = 1'b1;
    vh = '0;
    for (int e = 0; e < 10; e++) begin
      tick();
      vh[e] = bus.event_valid;
    end
    bus.line_in = 1'b0;
    repeat (4) tick();
    chk("post_rst_hist", vh, 64'h20);
    chk("post_rst_evcnt", {56'd0, bus.event_cnt}, 64'd1);

    // clr_err on the same edge a glitch completes: clear wins
    run_pulse(3, 8, vh, sh);
    chk("pre_clr_glcnt", {56'd0, bus.glitch_cnt}, 64'd1);
    bus.line_in = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 2) bus.line_in = 1'b0;
      if (e == 4) bus.clr_err = 1'b1;
      if (e == 5) bus.clr_err = 1'b0;
    end
    chk("clr_beats_glitch", {56'd0, bus.glitch_cnt}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
